// File: rtl/pool_pkg.sv
// -----------------------------------------------------------------------------
// pool_pkg
// Shared definitions for the 2-D pooling controller:
//   - one-hot FSM state encoding (idle / run / flush / done)
//   - depth of the registered read-address adder pipeline
//   - clog2 helper used to size address and counter fields (never below 1 bit)
// -----------------------------------------------------------------------------
package pool_pkg;

    // Registered stages between the loop counters and rd_addr.
    localparam int unsigned ADDR_PIPE = 3;

    typedef enum logic [3:0] {
        StIdle  = 4'b0001,
        StRun   = 4'b0010,
        StFlush = 4'b0100,
        StDone  = 4'b1000
    } pool_state_e;

    // Bits needed to hold values 0..value-1; returns at least 1 so that
    // single-valued fields still get a legal vector width.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned res;
        res = 0;
        if (value > 1) begin
            for (int unsigned i = 0; i < 32; i++) begin
                if (((value - 1) >> i) != 0) begin
                    res = i + 1;
                end
            end
        end
        return (res == 0) ? 1 : res;
    endfunction

endpackage

// File: rtl/pool_ctrl_param_if.sv
// -----------------------------------------------------------------------------
// pool_ctrl_param_if
// Bundles the pooling controller's sequencer handshake and RAM address/enable
// signals.
//   master : the pooling controller (drives busy/done/clr and RAM addresses)
//   slave  : the layer sequencer / RAM side (drives pool_start)
// Build option POOL_ABORT_EN adds pool_abort (slave -> master) and
// pool_aborted (master -> slave).
// -----------------------------------------------------------------------------
interface pool_ctrl_param_if #(
    parameter int unsigned RD_AW = 10,
    parameter int unsigned WR_AW = 8
);
    logic             pool_start;
    logic             pool_busy;
    logic             pool_done;
    logic             pool_clr;
    logic [RD_AW-1:0] rd_addr;
    logic [WR_AW-1:0] wr_addr;
    logic             wr_en;
`ifdef POOL_ABORT_EN
    logic             pool_abort;
    logic             pool_aborted;

    modport master (
        input  pool_start, pool_abort,
        output pool_busy, pool_done, pool_clr, rd_addr, wr_addr, wr_en, pool_aborted
    );
    modport slave (
        output pool_start, pool_abort,
        input  pool_busy, pool_done, pool_clr, rd_addr, wr_addr, wr_en, pool_aborted
    );
`else
    modport master (
        input  pool_start,
        output pool_busy, pool_done, pool_clr, rd_addr, wr_addr, wr_en
    );
    modport slave (
        output pool_start,
        input  pool_busy, pool_done, pool_clr, rd_addr, wr_addr, wr_en
    );
`endif
endinterface

// File: rtl/pool_delay_line.sv
// -----------------------------------------------------------------------------
// pool_delay_line
// WIDTH-bit shift register, DEPTH stages. q_o is d_i delayed by DEPTH cycles.
// Ports:
//   clk_i   clock
//   rst_ni  asynchronous active-low reset, clears every stage
//   flush_i synchronous clear of every stage (the value on d_i is dropped too)
//   d_i     data in
//   q_o     data out (registered, last stage)
// -----------------------------------------------------------------------------
module pool_delay_line #(
    parameter int unsigned WIDTH = 1,
    parameter int unsigned DEPTH = 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             flush_i,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    if (DEPTH < 1 || WIDTH < 1) begin : g_bad_param
        $error("pool_delay_line: DEPTH and WIDTH must be at least 1");
    end

    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [WIDTH-1:0] stage_d [DEPTH];

    always_comb begin
        stage_d[0] = flush_i ? '0 : d_i;
        for (int unsigned i = 1; i < DEPTH; i++) begin
            stage_d[i] = flush_i ? '0 : stage_q[i-1];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stage_q <= '{default: '0};
        end else begin
            stage_q <= stage_d;
        end
    end

    assign q_o = stage_q[DEPTH-1];

endmodule

// File: rtl/pool_ctrl_param.sv
// -----------------------------------------------------------------------------
// pool_ctrl_param
// Control and address generator for a configurable 2-D pooling layer. Walks the
// kernel (kx fastest, then ky), output column/row (ox, oy) and channel loops,
// issues feature-RAM read addresses through a 3-stage adder pipeline, and
// issues accumulator clear plus output-RAM write address/enable aligned with
// the datapath (which sees read data MEM_LAT cycles after rd_addr).
// Ports:
//   clk         clock
//   rst_n       asynchronous active-low reset
//   bus.master  pool_start in; pool_busy, pool_done, pool_clr, rd_addr,
//               wr_addr, wr_en out
// Build option POOL_ABORT_EN: adds bus.pool_abort (return to idle from run or
// flush, in-flight clr/write slots dropped) and the bus.pool_aborted pulse.
// -----------------------------------------------------------------------------
module pool_ctrl_param
    import pool_pkg::*;
#(
    parameter int unsigned IN_W    = 28,
    parameter int unsigned IN_H    = 28,
    parameter int unsigned K       = 2,
    parameter int unsigned STRIDE  = 2,
    parameter int unsigned CH      = 1,
    parameter int unsigned MEM_LAT = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    pool_ctrl_param_if.master bus
);

    if (K < 1 || K > 8 || K > IN_W || K > IN_H || STRIDE == 0 || STRIDE > K ||
        CH < 1 || CH > 16 || MEM_LAT > 4) begin : g_bad_param
        $error("pool_ctrl_param: illegal parameter set");
    end

    // Guarded so that an illegal set reaches the $error above instead of
    // tripping over a divide-by-zero or underflow first.
    localparam int unsigned SAFE_S   = (STRIDE == 0) ? 1 : STRIDE;
    localparam int unsigned OUT_W    = ((IN_W >= K) ? IN_W - K : 0) / SAFE_S + 1;
    localparam int unsigned OUT_H    = ((IN_H >= K) ? IN_H - K : 0) / SAFE_S + 1;
    localparam int unsigned RD_AW    = clog2(CH * IN_W * IN_H);
    localparam int unsigned WR_AW    = clog2(CH * OUT_W * OUT_H);
    localparam int unsigned TOT_LAT  = ADDR_PIPE + MEM_LAT + 1;
    localparam int unsigned KW       = clog2(K);
    localparam int unsigned OXW      = clog2(OUT_W);
    localparam int unsigned OYW      = clog2(OUT_H);
    localparam int unsigned CHW      = clog2(CH);
    localparam int unsigned FLW      = clog2(TOT_LAT);

    localparam logic [KW-1:0]  K_LAST   = KW'(K - 1);
    localparam logic [OXW-1:0] OX_LAST  = OXW'(OUT_W - 1);
    localparam logic [OYW-1:0] OY_LAST  = OYW'(OUT_H - 1);
    localparam logic [CHW-1:0] CH_LAST  = CHW'(CH - 1);
    localparam logic [FLW-1:0] FL_LAST  = FLW'(TOT_LAT - 1);

    typedef logic [RD_AW-1:0] rd_addr_t;
    typedef logic [WR_AW-1:0] wr_addr_t;

    // ---------------------------------------------------------------- FSM --
    pool_state_e    state_q, state_d;
    logic [FLW-1:0] flush_cnt_q, flush_cnt_d;
    logic           run;
    logic           cnt_last;
    logic           abort_req;

    assign run = (state_q == StRun);

`ifdef POOL_ABORT_EN
    logic aborted_q;

    assign abort_req = bus.pool_abort & ((state_q == StRun) | (state_q == StFlush));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            aborted_q <= 1'b0;
        end else begin
            aborted_q <= abort_req;
        end
    end

    assign bus.pool_aborted = aborted_q;
`else
    assign abort_req = 1'b0;
`endif

    always_comb begin
        state_d     = state_q;
        flush_cnt_d = '0;
        unique case (state_q)
            StIdle: begin
                if (bus.pool_start) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (abort_req) begin
                    state_d = StIdle;
                end else if (cnt_last) begin
                    state_d = StFlush;
                end
            end
            StFlush: begin
                // Held TOT_LAT cycles so the last write leaves the delay lines.
                if (abort_req) begin
                    state_d = StIdle;
                end else if (flush_cnt_q == FL_LAST) begin
                    state_d = StDone;
                end else begin
                    flush_cnt_d = flush_cnt_q + FLW'(1);
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            flush_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    // ------------------------------------------------------- loop counters --
    logic [KW-1:0]  kx_q, kx_d, ky_q, ky_d;
    logic [OXW-1:0] ox_q, ox_d;
    logic [OYW-1:0] oy_q, oy_d;
    logic [CHW-1:0] ch_q, ch_d;

    assign cnt_last = (kx_q == K_LAST) && (ky_q == K_LAST) && (ox_q == OX_LAST) &&
                      (oy_q == OY_LAST) && (ch_q == CH_LAST);

    // Outside RUN the counters sit at zero; the final RUN cycle wraps them
    // there naturally, and an abort forces them there.
    always_comb begin
        kx_d = '0;
        ky_d = '0;
        ox_d = '0;
        oy_d = '0;
        ch_d = '0;
        if (run && !abort_req) begin
            kx_d = kx_q;
            ky_d = ky_q;
            ox_d = ox_q;
            oy_d = oy_q;
            ch_d = ch_q;
            if (kx_q != K_LAST) begin
                kx_d = kx_q + KW'(1);
            end else begin
                kx_d = '0;
                if (ky_q != K_LAST) begin
                    ky_d = ky_q + KW'(1);
                end else begin
                    ky_d = '0;
                    if (ox_q != OX_LAST) begin
                        ox_d = ox_q + OXW'(1);
                    end else begin
                        ox_d = '0;
                        if (oy_q != OY_LAST) begin
                            oy_d = oy_q + OYW'(1);
                        end else begin
                            oy_d = '0;
                            ch_d = (ch_q != CH_LAST) ? ch_q + CHW'(1) : '0;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            kx_q <= '0;
            ky_q <= '0;
            ox_q <= '0;
            oy_q <= '0;
            ch_q <= '0;
        end else begin
            kx_q <= kx_d;
            ky_q <= ky_d;
            ox_q <= ox_d;
            oy_q <= oy_d;
            ch_q <= ch_d;
        end
    end

    // ------------------------------------------------ read address pipeline --
    // Stage 1: row/column inside the plane; stage 2: plane offset and channel
    // base; stage 3: final sum. rd_addr only updates for valid RUN samples so
    // it holds its last value between runs.
    rd_addr_t row_q, row_d, col_q, col_d, chn_q, chn_d;
    rd_addr_t pix_q, pix_d, base_q, base_d;
    rd_addr_t rd_addr_q, rd_addr_d;
    logic     s1_vld_q, s2_vld_q;

    always_comb begin
        row_d     = rd_addr_t'(oy_q) * rd_addr_t'(SAFE_S) + rd_addr_t'(ky_q);
        col_d     = rd_addr_t'(ox_q) * rd_addr_t'(SAFE_S) + rd_addr_t'(kx_q);
        chn_d     = rd_addr_t'(ch_q);
        pix_d     = row_q * rd_addr_t'(IN_W) + col_q;
        base_d    = chn_q * rd_addr_t'(IN_W * IN_H);
        rd_addr_d = s2_vld_q ? base_q + pix_q : rd_addr_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row_q     <= '0;
            col_q     <= '0;
            chn_q     <= '0;
            pix_q     <= '0;
            base_q    <= '0;
            rd_addr_q <= '0;
            s1_vld_q  <= 1'b0;
            s2_vld_q  <= 1'b0;
        end else begin
            row_q     <= row_d;
            col_q     <= col_d;
            chn_q     <= chn_d;
            pix_q     <= pix_d;
            base_q    <= base_d;
            rd_addr_q <= rd_addr_d;
            s1_vld_q  <= run;
            s2_vld_q  <= s1_vld_q;
        end
    end

    // -------------------------------------------- clear / write alignment --
    // pool_clr lands with the window's first datum at the datapath
    // (ADDR_PIPE + MEM_LAT); the write lands one cycle after the last datum.
    logic     clr_in, wr_in;
    wr_addr_t wr_addr_in;
    logic     clr_dly, wr_en_dly;
    wr_addr_t wr_addr_dly;

    always_comb begin
        clr_in     = run && (kx_q == '0) && (ky_q == '0);
        wr_in      = run && (kx_q == K_LAST) && (ky_q == K_LAST);
        wr_addr_in = wr_addr_t'(ch_q) * wr_addr_t'(OUT_W * OUT_H) +
                     wr_addr_t'(oy_q) * wr_addr_t'(OUT_W) + wr_addr_t'(ox_q);
    end

    pool_delay_line #(
        .WIDTH (1),
        .DEPTH (TOT_LAT - 1)
    ) u_clr_dly (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .flush_i (abort_req),
        .d_i     (clr_in),
        .q_o     (clr_dly)
    );

    pool_delay_line #(
        .WIDTH (1),
        .DEPTH (TOT_LAT)
    ) u_wr_en_dly (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .flush_i (abort_req),
        .d_i     (wr_in),
        .q_o     (wr_en_dly)
    );

    pool_delay_line #(
        .WIDTH (WR_AW),
        .DEPTH (TOT_LAT)
    ) u_wr_addr_dly (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .flush_i (abort_req),
        .d_i     (wr_addr_in),
        .q_o     (wr_addr_dly)
    );

    // -------------------------------------------------------------- outputs --
    assign bus.pool_busy = (state_q != StIdle);
    assign bus.pool_done = (state_q == StDone);
    assign bus.pool_clr  = clr_dly;
    assign bus.rd_addr   = rd_addr_q;
    assign bus.wr_en     = wr_en_dly;
    assign bus.wr_addr   = wr_addr_dly;

endmodule
